// File: rtl/mem_access_stage.sv
// Memory stage: word-addressed data memory with fixed access latency and a
// stall FSM so the MEM/WB register can latch every cycle without an enable.
module mem_access_stage #(
  parameter int DEPTH   = 256,
  parameter int AW      = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] EX_MEM_ALUResult,
  input  logic [31:0] EX_MEM_WriteData,
  input  logic        EX_MEM_MemRead,
  input  logic        EX_MEM_MemWrite,
  input  logic        EX_MEM_RegWrite,
  output logic [31:0] MemReadData,
  output logic        MEM_RegWrite,
  output logic        MemStall,
  output logic        MemMisalign
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] mem [DEPTH];

  logic          req;
  logic          in_range;
  logic          misalign;
  logic          last_wait;
  logic          do_store;
  logic          do_load;
  logic [AW-1:0] idx;

  function automatic logic addr_in_range(input logic [31:0] addr);
    return addr[31:AW+2] == '0;
  endfunction

  function automatic logic [AW-1:0] word_index(input logic [31:0] addr);
    return addr[AW+1:2];
  endfunction

  assign req       = EX_MEM_MemRead | EX_MEM_MemWrite;
  assign idx       = word_index(EX_MEM_ALUResult);
  assign in_range  = addr_in_range(EX_MEM_ALUResult);
  assign misalign  = |EX_MEM_ALUResult[1:0];
  assign last_wait = (state == BUSY) && (cnt == 4'd0);
  // A simultaneous read and write request is handled as a store only.
  assign do_store  = last_wait && EX_MEM_MemWrite;
  assign do_load   = last_wait && EX_MEM_MemRead && !EX_MEM_MemWrite;

  // Reset also drops the stall so the pipeline is not frozen while held in reset.
  assign MemStall     = !rst && (((state == IDLE) && req) || (state == BUSY));
  assign MEM_RegWrite = EX_MEM_RegWrite & ~MemStall;

  // Memory write port: gated by reset so an aborted access never commits.
  always_ff @(posedge clk) begin
    if (!rst && do_store && in_range) begin
      mem[idx] <= EX_MEM_WriteData;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      MemReadData <= 32'd0;
      MemMisalign <= 1'b0;
    end else begin
      MemMisalign <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            cnt   <= CNT_INIT;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (do_load) begin
              MemReadData <= in_range ? mem[idx] : 32'd0;
            end
            MemMisalign <= req && misalign;
            state       <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: one instance at LATENCY=2, one at
// LATENCY=1; sel routes stimulus to one instance while the other idles.
module tb_mem_access_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int sel = 0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic rd = 1'b0, wr = 1'b0, rw = 1'b0;

  logic [31:0] a_addr, a_wdata, b_addr, b_wdata, a_rdata, b_rdata;
  logic a_rd, a_wr, a_rw, b_rd, b_wr, b_rw;
  logic a_mrw, a_stall, a_mis, b_mrw, b_stall, b_mis;

  logic [31:0] rdata_o;
  logic stall_o, mis_o, rw_o;

  always_comb begin
    a_addr = addr;  a_wdata = wdata;  b_addr = addr;  b_wdata = wdata;
    a_rd = 1'b0; a_wr = 1'b0; a_rw = 1'b0;
    b_rd = 1'b0; b_wr = 1'b0; b_rw = 1'b0;
    if (sel == 0) begin a_rd = rd; a_wr = wr; a_rw = rw; end
    else          begin b_rd = rd; b_wr = wr; b_rw = rw; end
    rdata_o = (sel == 0) ? a_rdata : b_rdata;
    stall_o = (sel == 0) ? a_stall : b_stall;
    mis_o   = (sel == 0) ? a_mis   : b_mis;
    rw_o    = (sel == 0) ? a_mrw   : b_mrw;
  end

  mem_access_stage #(.DEPTH(256), .AW(8), .LATENCY(2)) dut_a (
    .clk(clk), .rst(rst),
    .EX_MEM_ALUResult(a_addr), .EX_MEM_WriteData(a_wdata),
    .EX_MEM_MemRead(a_rd), .EX_MEM_MemWrite(a_wr), .EX_MEM_RegWrite(a_rw),
    .MemReadData(a_rdata), .MEM_RegWrite(a_mrw),
    .MemStall(a_stall), .MemMisalign(a_mis)
  );

  mem_access_stage #(.DEPTH(256), .AW(8), .LATENCY(1)) dut_b (
    .clk(clk), .rst(rst),
    .EX_MEM_ALUResult(b_addr), .EX_MEM_WriteData(b_wdata),
    .EX_MEM_MemRead(b_rd), .EX_MEM_MemWrite(b_wr), .EX_MEM_RegWrite(b_rw),
    .MemReadData(b_rdata), .MEM_RegWrite(b_mrw),
    .MemStall(b_stall), .MemMisalign(b_mis)
  );

  typedef struct {
    logic [31:0] data;
    logic        mis;
  } sb_t;

  sb_t         sbq[$];
  logic [31:0] model [2][256];
  logic [31:0] last_rd [2];
  int total = 0;
  int bad   = 0;

  // Expected results are queued as the access is issued and checked at DONE.
  task automatic mem_op(input logic rdv, input logic wrv, input logic [31:0] a,
                        input logic [31:0] d, input logic rwv, input string tag);
    sb_t  e;
    int   stalls;
    int   lat;
    logic inr;
    lat   = (sel == 0) ? 2 : 1;
    inr   = (a[31:10] == 22'd0);
    e.mis = (a[1:0] != 2'b00);
    if (wrv) begin
      if (inr) model[sel][a[9:2]] = d;
      e.data = last_rd[sel];
    end else begin
      e.data = inr ? model[sel][a[9:2]] : 32'd0;
      last_rd[sel] = e.data;
    end
    sbq.push_back(e);

    @(negedge clk);
    addr = a; wdata = d; rd = rdv; wr = wrv; rw = rwv;
    #1;
    stalls = 0;
    while (stall_o === 1'b1 && stalls < 40) begin
      total++;
      if (rw_o !== 1'b0) begin
        bad++;
        $display("FAIL %s regwrite_in_stall: got %b want 0", tag, rw_o);
      end
      stalls++;
      @(negedge clk); #1;
    end
    total++;
    if (stalls != lat + 1) begin
      bad++;
      $display("FAIL %s stall_cycles: got %0d want %0d", tag, stalls, lat + 1);
    end
    e = sbq.pop_front();
    total++;
    if (rdata_o !== e.data) begin
      bad++;
      $display("FAIL %s read_data: got %h want %h", tag, rdata_o, e.data);
    end
    total++;
    if (mis_o !== e.mis) begin
      bad++;
      $display("FAIL %s misalign: got %b want %b", tag, mis_o, e.mis);
    end
    total++;
    if (rw_o !== rwv) begin
      bad++;
      $display("FAIL %s regwrite_done: got %b want %b", tag, rw_o, rwv);
    end
    rd = 1'b0; wr = 1'b0; rw = 1'b0;
  endtask

  task automatic alu_op(input logic rwv, input string tag);
    @(negedge clk);
    addr = 32'h0000_1234; rd = 1'b0; wr = 1'b0; rw = rwv;
    #1;
    total++;
    if (stall_o !== 1'b0) begin
      bad++;
      $display("FAIL %s alu_stall: got %b want 0", tag, stall_o);
    end
    total++;
    if (rw_o !== rwv) begin
      bad++;
      $display("FAIL %s alu_regwrite: got %b want %b", tag, rw_o, rwv);
    end
  endtask

  task automatic test_reset();
    sel = 0; rst = 1'b1; wr = 1'b1; addr = 32'h10; wdata = 32'h1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      total++;
      if (stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", stall_o); end
      total++;
      if (rdata_o !== 32'd0) begin bad++; $display("FAIL reset_rdata: got %h want 0", rdata_o); end
      total++;
      if (mis_o !== 1'b0) begin bad++; $display("FAIL reset_mis: got %b want 0", mis_o); end
    end
    rst = 1'b0; wr = 1'b0;
    last_rd[0] = 32'd0; last_rd[1] = 32'd0;
    @(negedge clk); #1;
    total++;
    if (stall_o !== 1'b0) begin bad++; $display("FAIL reset_idle_stall: got %b want 0", stall_o); end
  endtask

  task automatic test_store_load();
    sel = 0;
    mem_op(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, "sl_store");
    mem_op(1'b1, 1'b0, 32'h10, 32'h0,        1'b1, "sl_load");
  endtask

  task automatic test_out_of_range();
    sel = 0;
    mem_op(1'b0, 1'b1, 32'h0,   32'hCAFE0001, 1'b0, "oor_init");
    mem_op(1'b1, 1'b0, 32'h400, 32'h0,        1'b1, "oor_load");
    mem_op(1'b0, 1'b1, 32'h400, 32'h00000BAD, 1'b0, "oor_store");
    mem_op(1'b1, 1'b0, 32'h0,   32'h0,        1'b1, "oor_check");
  endtask

  task automatic test_misalign();
    sel = 0;
    mem_op(1'b0, 1'b1, 32'h13, 32'h12345678, 1'b0, "mis_store");
    @(negedge clk); #1;
    total++;
    if (mis_o !== 1'b0) begin bad++; $display("FAIL mis_pulse_len: got %b want 0", mis_o); end
    mem_op(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, "mis_load");
  endtask

  task automatic test_illegal();
    sel = 0;
    mem_op(1'b1, 1'b1, 32'h30, 32'h5555AAAA, 1'b1, "both_req");
    mem_op(1'b1, 1'b0, 32'h30, 32'h0,        1'b1, "both_check");
  endtask

  task automatic test_abort();
    sel = 0;
    mem_op(1'b0, 1'b1, 32'h20, 32'h1, 1'b0, "abort_init");
    @(negedge clk);
    addr = 32'h20; wdata = 32'hA5A5A5A5; wr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (stall_o !== 1'b0) begin bad++; $display("FAIL abort_stall_rst: got %b want 0", stall_o); end
    @(negedge clk); #1;
    total++;
    if (rdata_o !== 32'd0) begin bad++; $display("FAIL abort_rdata: got %h want 0", rdata_o); end
    rst = 1'b0; wr = 1'b0;
    last_rd[0] = 32'd0; last_rd[1] = 32'd0;
    @(negedge clk); #1;
    total++;
    if (stall_o !== 1'b0) begin bad++; $display("FAIL abort_idle_stall: got %b want 0", stall_o); end
    mem_op(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, "abort_check");
  endtask

  task automatic test_back_to_back();
    sel = 0;
    mem_op(1'b0, 1'b1, 32'h44, 32'h0BADF00D, 1'b0, "b2b_store");
    mem_op(1'b1, 1'b0, 32'h44, 32'h0,        1'b1, "b2b_load1");
    mem_op(1'b1, 1'b0, 32'h10, 32'h0,        1'b1, "b2b_load2");
  endtask

  task automatic test_mixed_stream();
    sel = 1;
    mem_op(1'b0, 1'b1, 32'h40, 32'h11112222, 1'b0, "mx_store1");
    mem_op(1'b0, 1'b1, 32'h84, 32'h33334444, 1'b0, "mx_store2");
    alu_op(1'b1, "mx_alu1");
    mem_op(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, "mx_load1");
    mem_op(1'b1, 1'b0, 32'h84, 32'h0, 1'b1, "mx_load2");
    alu_op(1'b1, "mx_alu2");
    @(negedge clk); #1;
    total++;
    if (stall_o !== 1'b0) begin bad++; $display("FAIL mx_tail_stall: got %b want 0", stall_o); end
    total++;
    if (rdata_o !== 32'h33334444) begin
      bad++;
      $display("FAIL mx_tail_rdata: got %h want 33334444", rdata_o);
    end
    rw = 1'b0;
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_out_of_range();
    test_misalign();
    test_illegal();
    test_abort();
    test_back_to_back();
    test_mixed_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
